// File: rtl/lfsr_seq_pkg.sv
// Shared types and helpers for the LFSR stream sequencer.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package lfsr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // All-ones is the lock-up state of an XNOR-feedback LFSR. The caller
  // truncates the 64-bit result to its own width.
  function automatic logic [63:0] lockup_val(input int unsigned width);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/lfsr_seq_cnt.sv
// Word counter, last-beat detect and saturating wrap counter for the sequencer.
// Latency: last is combinational from beat; counts update one cycle after a beat.
// Backpressure: counts only on accepted beats, so stalls leave all state untouched.
// Ports: clk/rst (sync active-high), clear (new run), beat (accepted word),
//        lfsr_done (LFSR is back at its seed), len (captured word count),
//        last (this beat is the final one), wrap_cnt (wraps seen this run).
module lfsr_seq_cnt #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             beat,
  input  logic             lfsr_done,
  input  logic [LEN_W-1:0] len,
  output logic             last,
  output logic [LEN_W-1:0] wrap_cnt
);

  logic [LEN_W-1:0] word_cnt;

  // len is never zero while beats are being accepted, so len-1 cannot wrap.
  assign last = beat && (word_cnt == (len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      wrap_cnt <= '0;
    end else if (clear) begin
      word_cnt <= '0;
      wrap_cnt <= '0;
    end else if (beat) begin
      word_cnt <= word_cnt + LEN_W'(1);
      // Beat 0 is the seed itself, so its Done flag is not a wrap.
      if ((word_cnt != '0) && lfsr_done && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer that seeds an external XNOR LFSR and streams N of its states.
// Latency: one SEED cycle after start, then one word per accepted beat; Done/Err
//          are registered pulses one cycle after the causing event.
// Backpressure: o_Valid/i_Ready; the LFSR only steps on accepted beats, so o_Data
//               holds while i_Ready is low.
// Ports: command (i_Start/i_Seed/i_Len/i_Abort), status (o_Busy/o_Done/o_Err/
//        o_Wrap_Cnt), stream (o_Data/o_Valid/i_Ready), LFSR control/observe.
module lfsr_seq_ctrl #(
  parameter int NUM_BITS = 3,
  parameter int LEN_W    = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Start,
  input  logic [NUM_BITS-1:0] i_Seed,
  input  logic [LEN_W-1:0]    i_Len,
  input  logic                i_Abort,
  output logic                o_Busy,
  output logic                o_Done,
  output logic                o_Err,
  output logic [LEN_W-1:0]    o_Wrap_Cnt,
  output logic [NUM_BITS-1:0] o_Data,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic                o_LFSR_Enable,
  output logic                o_LFSR_Seed_DV,
  output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  input  logic                i_LFSR_Done
);

  import lfsr_seq_pkg::*;

  localparam logic [NUM_BITS-1:0] LOCKUP = NUM_BITS'(lockup_val(NUM_BITS));

  state_t              state, state_nxt;
  logic [NUM_BITS-1:0] seed_q;
  logic [LEN_W-1:0]    len_q;
  logic                done_q, err_q;

  logic start_bad, seed_load, len_load, cnt_clear, enter_done;
  logic lfsr_en, seed_dv, valid, beat, last;

  always_comb begin
    state_nxt  = state;
    start_bad  = 1'b0;
    seed_load  = 1'b0;
    len_load   = 1'b0;
    cnt_clear  = 1'b0;
    enter_done = 1'b0;
    lfsr_en    = 1'b0;
    seed_dv    = 1'b0;
    valid      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (i_Start) begin
          if (i_Seed == LOCKUP) begin
            // Seeding the lock-up state would freeze the LFSR: reject.
            start_bad = 1'b1;
            state_nxt = state;
          end else begin
            seed_load = 1'b1;
            cnt_clear = 1'b1;
            if (i_Len == '0) begin
              state_nxt  = DONE;
              enter_done = 1'b1;
            end else begin
              len_load  = 1'b1;
              state_nxt = SEED;
            end
          end
        end
      end
      SEED: begin
        if (i_Abort) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          lfsr_en   = 1'b1;
          seed_dv   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        valid   = 1'b1;
        lfsr_en = i_Ready;
        if (i_Abort || last) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat = valid & i_Ready;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state  <= IDLE;
      seed_q <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= enter_done;
      err_q  <= start_bad;
      if (seed_load) seed_q <= i_Seed;
      if (len_load)  len_q  <= i_Len;
    end
  end

  lfsr_seq_cnt #(.LEN_W(LEN_W)) u_cnt (
    .clk       (i_Clk),
    .rst       (i_Rst),
    .clear     (cnt_clear),
    .beat      (beat),
    .lfsr_done (i_LFSR_Done),
    .len       (len_q),
    .last      (last),
    .wrap_cnt  (o_Wrap_Cnt)
  );

  assign o_Busy           = (state == SEED) || (state == RUN);
  assign o_Done           = done_q;
  assign o_Err            = err_q;
  assign o_Valid          = valid;
  // Gated so the stream bus reads zero outside RUN even though the LFSR keeps its contents.
  assign o_Data           = valid ? i_LFSR_Data : '0;
  assign o_LFSR_Enable    = lfsr_en;
  assign o_LFSR_Seed_DV   = seed_dv;
  // The LFSR's Done compare watches this continuously, so it only changes on an accepted start.
  assign o_LFSR_Seed_Data = seed_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl with a behavioural 3-bit XNOR LFSR attached.
// Expected words come from the LFSR's 7-state cycle table; a negedge monitor pops them.
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, ready;
  logic [2:0]  seed;
  logic [15:0] len;
  logic        busy, done, err, valid, lfsr_en, lfsr_sdv, lfsr_done;
  logic [15:0] wrap;
  logic [2:0]  data, lfsr_sdat, lfsr_data;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.NUM_BITS(3), .LEN_W(16)) dut (
    .i_Clk            (clk),
    .i_Rst            (rst),
    .i_Start          (start),
    .i_Seed           (seed),
    .i_Len            (len),
    .i_Abort          (abort),
    .o_Busy           (busy),
    .o_Done           (done),
    .o_Err            (err),
    .o_Wrap_Cnt       (wrap),
    .o_Data           (data),
    .o_Valid          (valid),
    .i_Ready          (ready),
    .o_LFSR_Enable    (lfsr_en),
    .o_LFSR_Seed_DV   (lfsr_sdv),
    .o_LFSR_Seed_Data (lfsr_sdat),
    .i_LFSR_Data      (lfsr_data),
    .i_LFSR_Done      (lfsr_done)
  );

  // External LFSR: XNOR feedback of the top two bits, Done when back at the seed.
  logic [2:0] lfsr_r = 3'b000;
  always @(posedge clk) begin
    if (lfsr_en) lfsr_r <= lfsr_sdv ? lfsr_sdat : {lfsr_r[1:0], ~(lfsr_r[2] ^ lfsr_r[1])};
  end
  assign lfsr_data = lfsr_r;
  assign lfsr_done = (lfsr_r == lfsr_sdat);

  // Reference: the order the 7 non-lock-up states are visited.
  int cyc [7] = '{0, 1, 3, 6, 5, 2, 4};

  logic [2:0]  exp_q[$];
  logic [15:0] exp_wrap_q[$];
  int checks = 0, errors = 0;
  int busy_cnt = 0, done_cnt = 0, err_cnt = 0, sdv_cnt = 0, valid_cnt = 0, beat_cnt = 0;
  bit prev_stall = 1'b0;
  logic [2:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int pos_of(input int s);
    for (int i = 0; i < 7; i++) if (cyc[i] == s) return i;
    return 0;
  endfunction

  // A run of n beats from seed s: words follow the cycle; a wrap occurs at every
  // 7th beat after the first.
  function automatic void push_exp(input int s, input int n, input bit with_wrap);
    int p;
    p = pos_of(s);
    for (int k = 0; k < n; k++) exp_q.push_back(3'(cyc[(p + k) % 7]));
    if (with_wrap) exp_wrap_q.push_back(16'((n == 0) ? 0 : (n - 1) / 7));
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy)     busy_cnt++;
      if (err)      err_cnt++;
      if (lfsr_sdv) sdv_cnt++;
      if (valid)    valid_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_wrap_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done pulse, expected none");
        end else begin
          chk("wrap_cnt", 32'(wrap), 32'(exp_wrap_q.pop_front()));
        end
      end
      if (!busy) chk("lfsr_quiet_when_idle", {30'd0, lfsr_en, lfsr_sdv}, 32'd0);
      if (valid) begin
        chk("enable_eq_accept", 32'(lfsr_en), 32'(ready));
        if (prev_stall) chk("data_stable_stall", 32'(data), 32'(prev_data));
      end
      if (valid && ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got word %0d, expected no beat", data);
        end else begin
          chk("data", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [2:0] s, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; seed = s; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int mode, input int budget);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk); #1;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
      n++;
    end
    chk("done_within_budget", 32'(done_cnt - base), 32'd1);
    ready = 1'b1;
  endtask

  initial begin
    int b0, d0, e0, s0, v0, bb, n, s, l;
    bit sent;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; seed = '0; len = '0;
    cycle(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, done, err, valid}, 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_lfsr_ctl", {29'd0, lfsr_en, lfsr_sdv, 1'b0}, 0);
    chk("rst_seed_data", 32'(lfsr_sdat), 0);
    rst = 1'b0;
    cycle(1);

    // Full stream, seed 0, 15 words, no backpressure.
    b0 = busy_cnt; d0 = done_cnt;
    push_exp(0, 15, 1);
    start_cmd(3'd0, 16'd15);
    wait_done(0, 200);
    cycle(3);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 16);
    chk("t1_done_pulses", 32'(done_cnt - d0), 1);
    chk("t1_words_left", 32'(exp_q.size()), 0);

    // Same stream with ready toggling.
    v0 = valid_cnt; bb = beat_cnt;
    push_exp(0, 15, 1);
    start_cmd(3'd0, 16'd15);
    wait_done(1, 200);
    cycle(2);
    chk("t2_beats", 32'(beat_cnt - bb), 15);
    chk("t2_words_left", 32'(exp_q.size()), 0);

    // Lock-up seed rejected.
    e0 = err_cnt; s0 = sdv_cnt; d0 = done_cnt; b0 = busy_cnt;
    start_cmd(3'd7, 16'd5);
    chk("t3_err_now", 32'(err), 1);
    cycle(3);
    chk("t3_err_pulses", 32'(err_cnt - e0), 1);
    chk("t3_no_busy", 32'(busy_cnt - b0), 0);
    chk("t3_no_seed_dv", 32'(sdv_cnt - s0), 0);
    chk("t3_no_done", 32'(done_cnt - d0), 0);
    chk("t3_seed_kept", 32'(lfsr_sdat), 0);

    // Zero-length run.
    v0 = valid_cnt; s0 = sdv_cnt;
    push_exp(3, 0, 1);
    start_cmd(3'd3, 16'd0);
    wait_done(0, 20);
    cycle(2);
    chk("t4_no_valid", 32'(valid_cnt - v0), 0);
    chk("t4_no_seed_dv", 32'(sdv_cnt - s0), 0);
    chk("t4_seed_captured", 32'(lfsr_sdat), 3);

    // Abort after 4 beats; a start while busy is ignored.
    d0 = done_cnt; e0 = err_cnt; bb = beat_cnt; sent = 1'b0; n = 0;
    push_exp(5, 4, 1);
    start_cmd(3'd5, 16'd100);
    while (n < 60) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (beat_cnt - bb >= 4) break;
      if (beat_cnt - bb == 1 && !sent) begin
        start = 1'b1; seed = 3'd1; len = 16'd3; sent = 1'b1;
      end
    end
    start = 1'b0; ready = 1'b0; abort = 1'b1;
    cycle(1);
    abort = 1'b0; ready = 1'b1;
    cycle(3);
    chk("t5_beats", 32'(beat_cnt - bb), 4);
    chk("t5_done_pulses", 32'(done_cnt - d0), 1);
    chk("t5_no_err_busy_start", 32'(err_cnt - e0), 0);
    chk("t5_seed_held", 32'(lfsr_sdat), 5);
    chk("t5_busy_after", 32'(busy), 0);

    // Reset in the middle of a run, then a fresh run.
    bb = beat_cnt; n = 0;
    push_exp(4, 10, 0);
    start_cmd(3'd4, 16'd10);
    while (beat_cnt - bb < 3 && n < 50) begin
      cycle(1);
      n++;
    end
    rst = 1'b1;
    cycle(1);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_stream", {28'd0, valid, data}, 0);
    chk("t6_rst_lfsr_ctl", {30'd0, lfsr_en, lfsr_sdv}, 0);
    chk("t6_rst_wrap", 32'(wrap), 0);
    chk("t6_rst_seed_data", 32'(lfsr_sdat), 0);
    rst = 1'b0;
    exp_q.delete();
    bb = beat_cnt;
    push_exp(2, 7, 1);
    start_cmd(3'd2, 16'd7);
    wait_done(0, 100);
    cycle(2);
    chk("t6_beats", 32'(beat_cnt - bb), 7);
    chk("t6_words_left", 32'(exp_q.size()), 0);

    // Randomized runs with random backpressure.
    for (int it = 0; it < 8; it++) begin
      s = int'($urandom_range(0, 7));
      l = int'($urandom_range(0, 24));
      if (s == 7) begin
        e0 = err_cnt;
        start_cmd(3'd7, 16'(l));
        cycle(2);
        chk("rnd_err", 32'(err_cnt - e0), 1);
      end else begin
        bb = beat_cnt;
        push_exp(s, l, 1);
        start_cmd(3'(s), 16'(l));
        wait_done(2, 400);
        cycle(2);
        chk("rnd_beats", 32'(beat_cnt - bb), 32'(l));
        chk("rnd_words_left", 32'(exp_q.size()), 0);
      end
    end

    chk("wrap_queue_drained", 32'(exp_wrap_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Sequencer for one external LFSR instance (NUM_BITS-wide, XNOR feedback, ports i_Enable/i_Seed_DV/i_Seed_Data/o_LFSR_Data/o_LFSR_Done).
- Accepts a start command carrying a seed and a word count.
- Seeds the LFSR, then streams exactly that many LFSR states out over a valid/ready interface. LFSR advances only on accepted beats.
- Reports completion and the number of full-period wraps seen. Sits between a register/command front-end and test-pattern consumers.

Parameters:
NUM_BITS, 3, LFSR width; must match the driven LFSR instance.
LEN_W, 16, width of word-count and wrap-count fields.

Ports:
i_Clk  in  1  clock
i_Rst  in  1  synchronous active-high reset
i_Start  in  1  start pulse; sampled only in IDLE or DONE
i_Seed  in  NUM_BITS  seed captured on accepted start
i_Len  in  LEN_W  number of words to stream, captured on accepted start
i_Abort  in  1  terminate stream; honoured in SEED and RUN
o_Busy  out  1  high in SEED and RUN
o_Done  out  1  one-cycle pulse on entry to DONE
o_Err  out  1  one-cycle pulse when a start is rejected
o_Wrap_Cnt  out  LEN_W  LFSR period wraps during the current/last run
o_Data  out  NUM_BITS  stream word (= i_LFSR_Data)
o_Valid  out  1  stream valid
i_Ready  in  1  stream ready
o_LFSR_Enable  out  1  to LFSR i_Enable
o_LFSR_Seed_DV  out  1  to LFSR i_Seed_DV
o_LFSR_Seed_Data  out  NUM_BITS  to LFSR i_Seed_Data
i_LFSR_Data  in  NUM_BITS  from LFSR o_LFSR_Data
i_LFSR_Done  in  1  from LFSR o_LFSR_Done

Behaviour:
- States: IDLE, SEED, RUN, DONE. Reset: IDLE, all outputs 0, seed/len/word/wrap registers 0.
- IDLE/DONE + i_Start:
  - i_Seed all-ones (XNOR lock-up state): o_Err pulses next cycle, state unchanged, registers unchanged.
  - i_Len==0: capture seed, clear wrap count, go directly to DONE (o_Done pulse), no LFSR activity.
  - Otherwise: capture seed/len, clear word and wrap counts, go to SEED.
- DONE with no i_Start: go to IDLE next cycle.
- SEED lasts exactly 1 cycle: o_LFSR_Enable=1, o_LFSR_Seed_DV=1, then RUN. i_Abort in SEED -> DONE, no load.
- RUN:
  - o_Valid=1, o_Data=i_LFSR_Data (combinational).
  - Accepted beat = o_Valid & i_Ready. o_LFSR_Enable = accepted beat (combinational). LFSR holds while i_Ready low; o_Data stays stable under backpressure.
  - Each accepted beat increments the word count. Beat k≥1 with i_LFSR_Done=1 increments o_Wrap_Cnt (saturating at all-ones). Beat 0 is never counted.
  - Accepted beat with word count == len-1 -> DONE.
  - i_Abort in RUN -> DONE next cycle. A beat accepted in the abort cycle still counts; abort wins over a final beat (same resulting state).
- o_LFSR_Seed_Data = captured seed, held stable from start until the next accepted start, because the LFSR Done compare uses it continuously.
- o_LFSR_Seed_DV=1 only in SEED. o_LFSR_Enable=0 outside SEED and RUN.
- i_Start while busy: ignored, no o_Err.
- o_Wrap_Cnt holds its value after DONE until the next accepted start.
- i_Rst mid-run: IDLE next edge, outputs 0. LFSR contents are not cleared; the next run reseeds.

Decomposition:
- Package lfsr_seq_pkg: state enum (IDLE, SEED, RUN, DONE) and a function returning the all-ones lock-up value for a given width.
- One sub-module is natural: lfsr_seq_cnt, holding the word counter, last-beat compare and saturating wrap counter. FSM stays in the top.

Test Plan:
- NUM_BITS=3, seed 0, len 15, i_Ready=1 -> 15 consecutive beats; beats 0, 7, 14 equal 0; o_Wrap_Cnt=2; o_Done pulses once; o_Busy high for 16 cycles (SEED + 15 RUN).
- Same stream with i_Ready toggling 1/0 every cycle -> identical 15-word sequence; o_Data stable while ready low; o_LFSR_Enable high only on accepted cycles.
- Start with seed 3'b111 -> o_Err pulse one cycle; state stays IDLE; o_Busy=0; no LFSR enable or seed pulse.
- Start with len 0 -> o_Done pulse with no o_Valid, no o_LFSR_Seed_DV; o_Wrap_Cnt=0.
- Start seed 5, len 100; i_Abort after 4 accepted beats -> DONE; exactly 4 beats delivered; second i_Start while busy ignored.
- i_Rst asserted mid-RUN -> all outputs 0 next cycle; new start with seed 2, len 7 -> first word 2, 7 beats, o_Wrap_Cnt=0.
